// File: rtl/ldpc_sched_pkg.sv
`default_nettype none
// ============================================================================
// ldpc_sched_pkg: shared types and latency helper for the LDPC shift scheduler.
// Rev 1.0
// ============================================================================
package ldpc_sched_pkg;

   // Tag index fields are sized for the largest supported base matrix.
   localparam int c_tag_idx_w = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic                   valid;
      logic [c_tag_idx_w-1:0] row;
      logic [c_tag_idx_w-1:0] col;
      logic                   row_end;
      logic                   last;
   } sched_tag_t;

   function automatic int sched_lat(input int maxz, input int stages);
      return ($clog2(maxz) + stages - 1) / stages;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_shift_sched_shifter.sv
`default_nettype none
// ============================================================================
// pipelinedCircularShifter: log-depth right rotator modulo MAXZ, registered
// every PIPE_STAGES_PER_CYCLE mux levels and always at the last level. Rev 1.0
// ============================================================================
module pipelinedCircularShifter #(
   parameter int MAXZ                  = 81,
   parameter int PIPE_STAGES_PER_CYCLE = 1
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic [MAXZ-1:0]          in_data,
   input  logic [$clog2(MAXZ)-1:0]  in_shift,
   output logic [MAXZ-1:0]          out_data
);
   localparam int c_sw = $clog2(MAXZ);

   logic [MAXZ-1:0] w_data  [0:c_sw];
   logic [c_sw-1:0] w_shift [0:c_sw];

   assign w_data[0]  = in_data;
   assign w_shift[0] = in_shift;

   generate
      for (genvar k = 0; k < c_sw; k++) begin : g_stage
         // Level k rotates by 2^k, reduced modulo the lifting size.
         localparam int c_amt = (1 << k) % MAXZ;
         logic [MAXZ-1:0] w_rot;
         logic [MAXZ-1:0] w_sel;

         for (genvar b = 0; b < MAXZ; b++) begin : g_bit
            assign w_rot[b] = w_data[k][(b + c_amt) % MAXZ];
         end

         assign w_sel = w_shift[k][k] ? w_rot : w_data[k];

         if (((k + 1) % PIPE_STAGES_PER_CYCLE == 0) || (k == c_sw - 1)) begin : g_reg
            logic [MAXZ-1:0] r_data;
            logic [c_sw-1:0] r_shift;
            always_ff @(posedge CLK) begin
               if (!rst_n) begin
                  r_data  <= '0;
                  r_shift <= '0;
               end else begin
                  r_data  <= w_sel;
                  r_shift <= w_shift[k];
               end
            end
            assign w_data[k+1]  = r_data;
            assign w_shift[k+1] = r_shift;
         end else begin : g_comb
            assign w_data[k+1]  = w_sel;
            assign w_shift[k+1] = w_shift[k];
         end
      end
   endgenerate

   assign out_data = w_data[c_sw];

endmodule
`default_nettype wire

// File: rtl/ldpc_shift_sched.sv
`default_nettype none
// ============================================================================
// ldpc_shift_sched: row-major base-matrix scan feeding a pipelined rotator with
// aligned slot tags. Define LDPC_SHIFT_SCHED_COUNT_EN for nnz_count. Rev 1.0
// ============================================================================
module ldpc_shift_sched
   import ldpc_sched_pkg::*;
#(
   parameter int MAXZ                  = 81,
   parameter int PIPE_STAGES_PER_CYCLE = 1,
   parameter int MB_ROWS               = 12,
   parameter int NB_COLS               = 24
) (
   input  logic                                    CLK,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic                                    hold,
   output logic                                    bm_rd_en,
   output logic [$clog2(MB_ROWS*NB_COLS)-1:0]      bm_addr,
   output logic [$clog2(NB_COLS)-1:0]              col_addr,
   input  logic                                    bm_null,
   input  logic [$clog2(MAXZ)-1:0]                 bm_shift,
   input  logic [MAXZ-1:0]                         col_data,
   output logic                                    out_valid,
   output logic [MAXZ-1:0]                         out_data,
   output logic [$clog2(MB_ROWS)-1:0]              out_row,
   output logic [$clog2(NB_COLS)-1:0]              out_col,
   output logic                                    out_row_end,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    err_shift,
   output logic [$clog2(MB_ROWS*NB_COLS+1)-1:0]    nnz_count
);
   localparam int c_sw     = $clog2(MAXZ);
   localparam int c_row_w  = $clog2(MB_ROWS);
   localparam int c_col_w  = $clog2(NB_COLS);
   localparam int c_addr_w = $clog2(MB_ROWS*NB_COLS);
   localparam int c_lat    = sched_lat(MAXZ, PIPE_STAGES_PER_CYCLE);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic                w_issue;
   logic                w_start;
   logic                w_last_entry;
   logic                w_shift_ok;
   logic [c_row_w-1:0]  r_row;
   logic [c_col_w-1:0]  r_col;
   logic [c_row_w-1:0]  r_iss_row;
   logic [c_col_w-1:0]  r_iss_col;
   logic                r_iss;
   logic                r_iss_last;
   logic                r_err;
   sched_tag_t          w_tag_in;
   sched_tag_t          w_tag [0:c_lat];

   assign w_start      = (r_state == IDLE) && start;
   assign w_last_entry = (r_row == c_row_w'(MB_ROWS-1)) && (r_col == c_col_w'(NB_COLS-1));

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!hold) begin
               w_issue = 1'b1;
               if (w_last_entry) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_tag[c_lat].last) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Counters wrap to (0,0) on the final issue so IDLE always presents address 0.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_start) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_issue) begin
         if (r_col == c_col_w'(NB_COLS-1)) begin
            r_col <= '0;
            r_row <= w_last_entry ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_iss      <= 1'b0;
         r_iss_row  <= '0;
         r_iss_col  <= '0;
         r_iss_last <= 1'b0;
      end else begin
         r_iss      <= w_issue;
         r_iss_row  <= r_row;
         r_iss_col  <= r_col;
         r_iss_last <= w_issue && w_last_entry;
      end
   end

   assign w_shift_ok = {1'b0, bm_shift} < (c_sw+1)'(MAXZ);

   // Slot tag is formed on the read-return cycle, in step with the shifter input.
   always_comb begin
      w_tag_in         = '0;
      w_tag_in.valid   = r_iss && !bm_null && w_shift_ok;
      w_tag_in.row     = c_tag_idx_w'(r_iss_row);
      w_tag_in.col     = c_tag_idx_w'(r_iss_col);
      w_tag_in.row_end = r_iss && (r_iss_col == c_col_w'(NB_COLS-1));
      w_tag_in.last    = r_iss_last;
   end

   assign w_tag[0] = w_tag_in;

   generate
      for (genvar i = 0; i < c_lat; i++) begin : g_tag_pipe
         sched_tag_t r_q;
         always_ff @(posedge CLK) begin
            if (!rst_n) begin
               r_q <= '0;
            end else begin
               r_q <= w_tag[i];
            end
         end
         assign w_tag[i+1] = r_q;
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_start) begin
         r_err <= 1'b0;
      end else if (r_iss && !w_shift_ok) begin
         r_err <= 1'b1;
      end
   end

`ifdef LDPC_SHIFT_SCHED_COUNT_EN
   logic [$clog2(MB_ROWS*NB_COLS+1)-1:0] r_nnz;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_nnz <= '0;
      end else if (w_start) begin
         r_nnz <= '0;
      end else if (w_tag_in.valid) begin
         r_nnz <= r_nnz + 1'b1;
      end
   end

   assign nnz_count = r_nnz;
`else
   assign nnz_count = '0;
`endif

   pipelinedCircularShifter #(
      .MAXZ                  (MAXZ),
      .PIPE_STAGES_PER_CYCLE (PIPE_STAGES_PER_CYCLE)
   ) u_shifter (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .in_data  (col_data),
      .in_shift (bm_shift),
      .out_data (out_data)
   );

   assign bm_rd_en    = w_issue;
   assign bm_addr     = c_addr_w'(r_row) * c_addr_w'(NB_COLS) + c_addr_w'(r_col);
   assign col_addr    = r_col;
   assign out_valid   = w_tag[c_lat].valid;
   assign out_row     = w_tag[c_lat].row[c_row_w-1:0];
   assign out_col     = w_tag[c_lat].col[c_col_w-1:0];
   assign out_row_end = w_tag[c_lat].row_end;
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DRAIN) && w_tag[c_lat].last;
   assign err_shift   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_shift_sched.sv
`default_nettype none
// ============================================================================
// tb_ldpc_shift_sched: directed scans on a 2x3 base matrix, Z=81, latency 7.
// Rev 1.0
// ============================================================================
module tb_ldpc_shift_sched;
   localparam int MAXZ    = 81;
   localparam int MB_ROWS = 2;
   localparam int NB_COLS = 3;
   localparam int N_ENT   = MB_ROWS * NB_COLS;
   localparam int LAT     = 7;

   localparam logic [80:0] P1 = 81'h1;
   localparam logic [80:0] P2 = 81'h1_A5C3_0F96_1234_5678_9ABC;
   localparam logic [80:0] P3 = 81'h0_FFFF_0000_1357_9BDF_0246;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        start;
   logic        hold;
   logic        bm_rd_en;
   logic [2:0]  bm_addr;
   logic [1:0]  col_addr;
   logic        bm_null;
   logic [6:0]  bm_shift;
   logic [80:0] col_data;
   logic        out_valid;
   logic [80:0] out_data;
   logic [0:0]  out_row;
   logic [1:0]  out_col;
   logic        out_row_end;
   logic        busy;
   logic        done;
   logic        err_shift;
   logic [2:0]  nnz_count;

   int n_assert = 0;
   int n_fail   = 0;

   logic        tbl_null  [N_ENT];
   int          tbl_shift [N_ENT];
   logic [80:0] tbl_data  [N_ENT];

   always #5 CLK = ~CLK;

   ldpc_shift_sched #(
      .MAXZ                  (MAXZ),
      .PIPE_STAGES_PER_CYCLE (1),
      .MB_ROWS               (MB_ROWS),
      .NB_COLS               (NB_COLS)
   ) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .start       (start),
      .hold        (hold),
      .bm_rd_en    (bm_rd_en),
      .bm_addr     (bm_addr),
      .col_addr    (col_addr),
      .bm_null     (bm_null),
      .bm_shift    (bm_shift),
      .col_data    (col_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_row_end (out_row_end),
      .busy        (busy),
      .done        (done),
      .err_shift   (err_shift),
      .nnz_count   (nnz_count)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [80:0] rotr(input logic [80:0] x, input int s);
      logic [161:0] d;
      d = {x, x};
      return d[s +: 81];
   endfunction

   // Base-matrix/column memory: answers a strobe one cycle later, garbage otherwise.
   initial begin
      logic       p_en;
      logic [2:0] p_addr;
      p_en     = 1'b0;
      p_addr   = '0;
      bm_null  = 1'b0;
      bm_shift = '0;
      col_data = '0;
      forever begin
         @(negedge CLK);
         if (p_en) begin
            bm_null  = tbl_null[p_addr];
            bm_shift = 7'(tbl_shift[p_addr]);
            col_data = tbl_data[p_addr];
         end else begin
            bm_null  = 1'($urandom_range(0, 1));
            bm_shift = 7'($urandom_range(0, 127));
            col_data = {$urandom, $urandom, 17'($urandom)};
         end
         #2;
         p_en   = bm_rd_en;
         p_addr = bm_addr;
      end
   end

   // hold_entry: first entry delayed by hold_len cycles (N_ENT = no hold).
   task automatic run_scan(input string name, input int hold_entry, input int hold_len);
      int   iss  [N_ENT];
      int   outk [N_ENT];
      int   done_k;
      int   n_valid;
      logic exp_err;
      logic exp_en;
      int   exp_addr;
      int   slot;
      logic ev;
      n_valid = 0;
      exp_err = 1'b0;
      for (int e = 0; e < N_ENT; e++) begin
         iss[e]  = 1 + e + ((e >= hold_entry) ? hold_len : 0);
         outk[e] = iss[e] + LAT + 1;
         if (tbl_shift[e] >= MAXZ) exp_err = 1'b1;
         else if (!tbl_null[e]) n_valid++;
      end
      done_k = outk[N_ENT-1];
      @(negedge CLK);
      start = 1'b1;
      hold  = 1'b0;
      for (int k = 1; k <= done_k + 3; k++) begin
         @(negedge CLK);
         start = (k == 7) || (k == done_k);
         hold  = (k > hold_entry) && (k <= hold_entry + hold_len);
         #1;
         exp_en   = 1'b0;
         exp_addr = 0;
         slot     = -1;
         for (int e = 0; e < N_ENT; e++) begin
            if (iss[e] == k) begin
               exp_en   = 1'b1;
               exp_addr = e;
            end
            if (outk[e] == k) slot = e;
         end
         check_eq($sformatf("%s k%0d busy", name, k), busy, k <= done_k);
         check_eq($sformatf("%s k%0d done", name, k), done, k == done_k);
         check_eq($sformatf("%s k%0d bm_rd_en", name, k), bm_rd_en, exp_en);
         if (exp_en) begin
            check_eq($sformatf("%s k%0d bm_addr", name, k), bm_addr, exp_addr);
            check_eq($sformatf("%s k%0d col_addr", name, k), col_addr, exp_addr % NB_COLS);
         end else if (hold) begin
            check_eq($sformatf("%s k%0d held bm_addr", name, k), bm_addr, hold_entry);
         end
         if (slot >= 0) begin
            ev = !tbl_null[slot] && (tbl_shift[slot] < MAXZ);
            check_eq($sformatf("%s k%0d out_valid", name, k), out_valid, ev);
            check_eq($sformatf("%s k%0d out_row_end", name, k), out_row_end, (slot % NB_COLS) == NB_COLS - 1);
            check_eq($sformatf("%s k%0d out_row", name, k), out_row, slot / NB_COLS);
            check_eq($sformatf("%s k%0d out_col", name, k), out_col, slot % NB_COLS);
            if (ev) begin
               check_eq($sformatf("%s k%0d out_data", name, k), out_data,
                        rotr(tbl_data[slot], tbl_shift[slot]));
            end
         end else begin
            check_eq($sformatf("%s k%0d idle out_valid", name, k), out_valid, 1'b0);
            check_eq($sformatf("%s k%0d idle out_row_end", name, k), out_row_end, 1'b0);
         end
      end
      start = 1'b0;
      hold  = 1'b0;
      check_eq($sformatf("%s err_shift", name), err_shift, exp_err);
`ifdef LDPC_SHIFT_SCHED_COUNT_EN
      check_eq($sformatf("%s nnz_count", name), nnz_count, n_valid);
`else
      check_eq($sformatf("%s nnz_count", name), nnz_count, 0);
`endif
   endtask

   initial begin
      logic saw;
      rst_n = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      tbl_null  = '{default: 1'b0};
      tbl_shift = '{1, 2, 3, 4, 5, 6};
      tbl_data  = '{default: P1};

      repeat (3) @(negedge CLK);
      #1;
      check_eq("reset busy", busy, 1'b0);
      check_eq("reset done", done, 1'b0);
      check_eq("reset out_valid", out_valid, 1'b0);
      check_eq("reset out_data", out_data, 81'h0);
      check_eq("reset out_row_end", out_row_end, 1'b0);
      check_eq("reset bm_rd_en", bm_rd_en, 1'b0);
      check_eq("reset bm_addr", bm_addr, 3'd0);
      check_eq("reset err_shift", err_shift, 1'b0);
      check_eq("reset nnz_count", nnz_count, 3'd0);
      @(negedge CLK);
      rst_n = 1'b1;

      run_scan("basic", N_ENT, 0);

      tbl_null  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl_shift = '{7, 8, 9, 10, 11, 12};
      tbl_data  = '{default: P2};
      run_scan("nulls", N_ENT, 0);

      tbl_null  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl_shift = '{20, 33, 0, 47, 62, 75};
      tbl_data  = '{P3, P2, P3, P1, P3, P2};
      run_scan("hold", 3, 3);

      tbl_null  = '{default: 1'b0};
      tbl_shift = '{5, 10, 15, 90, 25, 30};
      tbl_data  = '{default: P2};
      run_scan("badshift", N_ENT, 0);

      // Abort a scan while entry 2 is being issued.
      tbl_shift = '{1, 2, 3, 4, 5, 6};
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      #1;
      check_eq("rstmid err cleared by start", err_shift, 1'b0);
      check_eq("rstmid busy running", busy, 1'b1);
      @(negedge CLK);
      @(negedge CLK);
      rst_n = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;
      #1;
      check_eq("rstmid busy", busy, 1'b0);
      check_eq("rstmid out_valid", out_valid, 1'b0);
      check_eq("rstmid bm_rd_en", bm_rd_en, 1'b0);
      check_eq("rstmid done", done, 1'b0);
      check_eq("rstmid nnz_count", nnz_count, 3'd0);
      saw = 1'b0;
      repeat (15) begin
         @(negedge CLK);
         #1;
         saw = saw | busy | done | out_valid;
      end
      check_eq("rstmid quiet after abort", saw, 1'b0);

      tbl_null  = '{default: 1'b0};
      tbl_shift = '{0, 80, 40, 17, 79, 33};
      tbl_data  = '{P2, P2, P3, P3, P1, P2};
      run_scan("clean", N_ENT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
